// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32x32 register file and field/immediate decoder.
// All id_* outputs are combinational from the held instruction; writeback may be forwarded into the reads.
module decode_stage #(
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic        id_funct7b5,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val,
    output logic [31:0] id_imm,
    output logic        id_we,
    output logic        id_illegal
);
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [6:0]  OP_FENCE  = 7'b0001111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] pc_r;
    logic [31:0] regs_r [32];

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic        writes_rd_s;
    logic        illegal_s;
    logic [31:0] imm_s;

    function automatic logic [31:0] imm_i_type(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s_type(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b_type(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u_type(input logic [31:0] w);
        return {w[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j_type(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // IF/ID register: reset beats flush, flush beats stall
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= 32'h0000_0000;
        end else if (flush) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end else if (!stall) begin
            valid_r <= if_valid;
            instr_r <= if_instr;
            pc_r    <= if_pc;
        end
    end

    // Register file; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    assign opcode_s = instr_r[6:0];
    assign funct3_s = instr_r[14:12];
    assign funct7_s = instr_r[31:25];
    assign rs1_s    = instr_r[19:15];
    assign rs2_s    = instr_r[24:20];

    // Per-opcode immediate format, destination usage and legality
    always_comb begin
        writes_rd_s = 1'b0;
        illegal_s   = 1'b0;
        imm_s       = 32'h0000_0000;
        case (opcode_s)
            OP_LUI, OP_AUIPC: begin
                writes_rd_s = 1'b1;
                imm_s       = imm_u_type(instr_r);
            end
            OP_JAL: begin
                writes_rd_s = 1'b1;
                imm_s       = imm_j_type(instr_r);
            end
            OP_JALR: begin
                writes_rd_s = 1'b1;
                imm_s       = imm_i_type(instr_r);
                illegal_s   = (funct3_s != 3'd0);
            end
            OP_BRANCH: begin
                imm_s     = imm_b_type(instr_r);
                illegal_s = (funct3_s == 3'd2) || (funct3_s == 3'd3);
            end
            OP_LOAD: begin
                writes_rd_s = 1'b1;
                imm_s       = imm_i_type(instr_r);
                illegal_s   = (funct3_s == 3'd3) || (funct3_s == 3'd6) || (funct3_s == 3'd7);
            end
            OP_STORE: begin
                imm_s     = imm_s_type(instr_r);
                illegal_s = (funct3_s > 3'd2);
            end
            OP_OPIMM: begin
                writes_rd_s = 1'b1;
                imm_s       = imm_i_type(instr_r);
                case (funct3_s)
                    3'd1:    illegal_s = (funct7_s != 7'h00);
                    3'd5:    illegal_s = (funct7_s != 7'h00) && (funct7_s != 7'h20);
                    default: illegal_s = 1'b0;
                endcase
            end
            OP_OP: begin
                writes_rd_s = 1'b1;
                if (funct7_s == 7'h00) begin
                    illegal_s = 1'b0;
                end else if (funct7_s == 7'h20) begin
                    illegal_s = (funct3_s != 3'd0) && (funct3_s != 3'd5);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_FENCE: begin
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        illegal_s = illegal_s | (instr_r[1:0] != 2'b11);
    end

    assign rd_s        = writes_rd_s ? instr_r[11:7] : 5'd0;
    assign id_valid    = valid_r;
    assign id_pc       = pc_r;
    assign id_opcode   = opcode_s;
    assign id_funct3   = funct3_s;
    assign id_funct7b5 = instr_r[30];
    assign id_rs1      = rs1_s;
    assign id_rs2      = rs2_s;
    assign id_rd       = rd_s;
    assign id_imm      = imm_s;
    assign id_illegal  = valid_r & illegal_s;
    assign id_we       = valid_r & ~illegal_s & writes_rd_s & (rd_s != 5'd0);

    // Register reads with optional same-cycle writeback forwarding
    always_comb begin
        if (rs1_s == 5'd0) begin
            id_rs1_val = 32'h0000_0000;
        end else if ((WB_BYPASS != 0) && wb_we && (wb_rd == rs1_s)) begin
            id_rs1_val = wb_data;
        end else begin
            id_rs1_val = regs_r[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            id_rs2_val = 32'h0000_0000;
        end else if ((WB_BYPASS != 0) && wb_we && (wb_rd == rs2_s)) begin
            id_rs2_val = wb_data;
        end else begin
            id_rs2_val = regs_r[rs2_s];
        end
    end
endmodule
